// File: rtl/partition_sweep_checker_if.sv
// Bundle of signals between the sweep checker and the partition under test.
// The master side is the checker: it drives the stimulus vector and reports
// results. The slave side provides start and the two partition responses.
interface partition_sweep_checker_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
);
  localparam int HD_W  = IN_W + $clog2(OUT_W + 1);
  localparam int ABS_W = IN_W + OUT_W;

  logic              start;
  logic [IN_W-1:0]   pi;
  logic [OUT_W-1:0]  po_exact;
  logic [OUT_W-1:0]  po_approx;
  logic              busy;
  logic              done;
  logic [IN_W:0]     err_count;
  logic [HD_W-1:0]   hd_sum;
  logic [ABS_W-1:0]  abs_sum;
  logic [OUT_W-1:0]  max_abs;
  logic [IN_W-1:0]   first_fail;

  modport master (
    input  start, po_exact, po_approx,
    output pi, busy, done, err_count, hd_sum, abs_sum, max_abs, first_fail
  );

  modport slave (
    output start, po_exact, po_approx,
    input  pi, busy, done, err_count, hd_sum, abs_sum, max_abs, first_fail
  );
endinterface

// File: rtl/partition_sweep_checker.sv
// Exhaustive sweep of one logic partition: walks pi through every input
// vector, waits SETTLE cycles per vector for the partition to settle, then
// compares approximate against exact output and accumulates error metrics.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, no sweep has run; waiting for start
// RUN   | sweeping; counting down settle cycles, sampling at zero
// DONE  | sweep finished; results held until the next start
module partition_sweep_checker #(
  parameter int IN_W   = 7,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  partition_sweep_checker_if.master   bus
);

  localparam int PC_W  = $clog2(OUT_W + 1);
  localparam int HD_W  = IN_W + PC_W;
  localparam int ABS_W = IN_W + OUT_W;
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [IN_W-1:0]    pi_q;
  logic               busy_q;
  logic               done_q;
  logic [IN_W:0]      err_q;
  logic [HD_W-1:0]    hd_q;
  logic [ABS_W-1:0]   abs_q;
  logic [OUT_W-1:0]   max_q;
  logic [IN_W-1:0]    first_q;

  logic               load;
  logic               sample;
  logic               finish;

  logic [OUT_W:0]     ext_exact;
  logic [OUT_W:0]     ext_approx;
  logic [OUT_W:0]     diff_w;
  logic [OUT_W-1:0]   abs_diff;
  logic [OUT_W-1:0]   xor_w;
  logic [PC_W-1:0]    hd_w;
  logic               mismatch;

  // Per-vector error terms: magnitude of the difference and bit distance.
  always_comb begin
    ext_exact  = {1'b0, bus.po_exact};
    ext_approx = {1'b0, bus.po_approx};
    diff_w     = (ext_exact >= ext_approx) ? (ext_exact - ext_approx)
                                           : (ext_approx - ext_exact);
    abs_diff   = diff_w[OUT_W-1:0];
    xor_w      = bus.po_exact ^ bus.po_approx;
    mismatch   = (xor_w != '0);
    hd_w       = '0;
    for (int i = 0; i < OUT_W; i++) begin
      hd_w = hd_w + PC_W'(xor_w[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath strobes; start only matters outside RUN.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sample    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (wait_cnt == '0) begin
          sample = 1'b1;
          if (&pi_q) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Vector stepping, settle down-counter and metric accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      pi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      hd_q     <= '0;
      abs_q    <= '0;
      max_q    <= '0;
      first_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        wait_cnt <= CNT_W'(SETTLE);
        pi_q     <= '0;
        busy_q   <= 1'b1;
        err_q    <= '0;
        hd_q     <= '0;
        abs_q    <= '0;
        max_q    <= '0;
        first_q  <= '0;
      end else if (state == S_RUN) begin
        if (!sample) begin
          wait_cnt <= wait_cnt - CNT_W'(1);
        end else begin
          if (mismatch) begin
            err_q <= err_q + (IN_W + 1)'(1);
            hd_q  <= hd_q + HD_W'(hd_w);
            abs_q <= abs_q + ABS_W'(abs_diff);
            if (abs_diff > max_q) begin
              max_q <= abs_diff;
            end
            if (err_q == '0) begin
              first_q <= pi_q;
            end
          end
          if (finish) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            pi_q     <= pi_q + IN_W'(1);
            wait_cnt <= CNT_W'(SETTLE);
          end
        end
      end
    end
  end

  assign bus.pi         = pi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err_count  = err_q;
  assign bus.hd_sum     = hd_q;
  assign bus.abs_sum    = abs_q;
  assign bus.max_abs    = max_q;
  assign bus.first_fail = first_q;

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Bench for partition_sweep_checker: three instances (SETTLE 0, 1, 3) driven
// by table-based partition models; results compared against a reference
// computed by direct enumeration of the tables or against fixed values.
module tb_partition_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] exact_tab  [128];
  logic [3:0] approx_tab [128];
  logic [2:0] start_a;

  partition_sweep_checker_if #(.IN_W(7), .OUT_W(4)) b0 ();
  partition_sweep_checker_if #(.IN_W(7), .OUT_W(4)) b1 ();
  partition_sweep_checker_if #(.IN_W(7), .OUT_W(4)) b3 ();

  partition_sweep_checker #(.IN_W(7), .OUT_W(4), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  partition_sweep_checker #(.IN_W(7), .OUT_W(4), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  partition_sweep_checker #(.IN_W(7), .OUT_W(4), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  assign b0.start = start_a[0];
  assign b1.start = start_a[1];
  assign b3.start = start_a[2];
  assign b0.po_exact = exact_tab[b0.pi];  assign b0.po_approx = approx_tab[b0.pi];
  assign b1.po_exact = exact_tab[b1.pi];  assign b1.po_approx = approx_tab[b1.pi];
  assign b3.po_exact = exact_tab[b3.pi];  assign b3.po_approx = approx_tab[b3.pi];

  logic        busy_a [3];
  logic        done_a [3];
  logic [6:0]  pi_a   [3];
  logic [7:0]  err_a  [3];
  logic [9:0]  hd_a   [3];
  logic [10:0] abs_a  [3];
  logic [3:0]  max_a  [3];
  logic [6:0]  ff_a   [3];

  assign busy_a[0] = b0.busy; assign busy_a[1] = b1.busy; assign busy_a[2] = b3.busy;
  assign done_a[0] = b0.done; assign done_a[1] = b1.done; assign done_a[2] = b3.done;
  assign pi_a[0]   = b0.pi;   assign pi_a[1]   = b1.pi;   assign pi_a[2]   = b3.pi;
  assign err_a[0]  = b0.err_count;  assign err_a[1] = b1.err_count;  assign err_a[2] = b3.err_count;
  assign hd_a[0]   = b0.hd_sum;     assign hd_a[1]  = b1.hd_sum;     assign hd_a[2]  = b3.hd_sum;
  assign abs_a[0]  = b0.abs_sum;    assign abs_a[1] = b1.abs_sum;    assign abs_a[2] = b3.abs_sum;
  assign max_a[0]  = b0.max_abs;    assign max_a[1] = b1.max_abs;    assign max_a[2] = b3.max_abs;
  assign ff_a[0]   = b0.first_fail; assign ff_a[1]  = b1.first_fail; assign ff_a[2]  = b3.first_fail;

  string nm [5] = '{"err_count", "hd_sum", "abs_sum", "max_abs", "first_fail"};
  int    obs [5];
  int    want [5];

  // Partition behaviours: 0 identity, 1 stuck bit0, 2 inverted,
  // 3 single mismatch at 0x55, otherwise random tables.
  task automatic set_tables(input int mode);
    logic [6:0] vv;
    for (int v = 0; v < 128; v++) begin
      vv = 7'(v);
      exact_tab[v] = vv[3:0];
      case (mode)
        0: approx_tab[v] = vv[3:0];
        1: approx_tab[v] = {vv[3:1], 1'b0};
        2: approx_tab[v] = ~vv[3:0];
        3: approx_tab[v] = (v == 'h55) ? (vv[3:0] ^ 4'h1) : vv[3:0];
        default: begin
          exact_tab[v]  = 4'($urandom_range(0, 15));
          approx_tab[v] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : exact_tab[v];
        end
      endcase
    end
  endtask

  // Reference metrics by plain enumeration of the tables.
  task automatic model();
    int cnt, hd, abs_s, mx, first, e, a, d;
    cnt = 0; hd = 0; abs_s = 0; mx = 0; first = 0;
    for (int v = 0; v < 128; v++) begin
      e = int'(exact_tab[v]);
      a = int'(approx_tab[v]);
      if (e != a) begin
        if (cnt == 0) first = v;
        cnt++;
        hd += $countones(exact_tab[v] ^ approx_tab[v]);
        d = (e > a) ? e - a : a - e;
        abs_s += d;
        if (d > mx) mx = d;
      end
    end
    want = '{cnt, hd, abs_s, mx, first};
  endtask

  task automatic sample_obs(input int sel);
    obs = '{int'(err_a[sel]), int'(hd_a[sel]), int'(abs_a[sel]), int'(max_a[sel]), int'(ff_a[sel])};
  endtask

  // Optionally starts a sweep, then follows it at negedges until done.
  // Measures busy length and checks each vector is held for a full slot.
  task automatic run_sweep(input int sel, input bit do_start, input int pulse_at, input int hold_at,
                           output int busy_cyc, output int pi_bad, output bit done_seen);
    int slot, cur, dwell;
    slot = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
    busy_cyc = 0; pi_bad = 0; done_seen = 1'b0; cur = 0; dwell = 0;
    if (do_start) begin
      @(negedge clk); start_a[sel] = 1'b1;
      @(negedge clk); start_a[sel] = 1'b0;
    end
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == pulse_at) start_a[sel] = 1'b1;
      if (cyc == pulse_at + 1) start_a[sel] = 1'b0;
      if (cyc == hold_at) start_a[sel] = 1'b1;
      if (done_a[sel]) begin
        done_seen = 1'b1;
        break;
      end
      if (busy_a[sel]) begin
        busy_cyc++;
        if (int'(pi_a[sel]) == cur) dwell++;
        else if (int'(pi_a[sel]) == cur + 1) begin
          if (dwell != slot) pi_bad++;
          cur = int'(pi_a[sel]); dwell = 1;
        end else begin
          pi_bad++;
          cur = int'(pi_a[sel]); dwell = 1;
        end
      end
    end
    if (cur != 127 || dwell != slot) pi_bad++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = '0;
    set_tables(0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (busy_a[s] !== 1'b0 || done_a[s] !== 1'b0 || pi_a[s] !== 7'd0) begin
        bad++;
        $display("FAIL reset_ctrl[%0d]: got busy=%b done=%b pi=%0d want 0 0 0", s, busy_a[s], done_a[s], pi_a[s]);
      end
      sample_obs(s);
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs[i] !== 0) begin
          bad++;
          $display("FAIL reset_%s[%0d]: got %0d want 0", nm[i], s, obs[i]);
        end
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Fixed-pattern sweep on the SETTLE=1 instance against known results.
  task automatic test_pattern(input int mode, input string tag, input int e0, input int e1,
                              input int e2, input int e3, input int e4);
    int bc, pb; bit ds;
    set_tables(mode);
    run_sweep(1, 1'b1, -1, -1, bc, pb, ds);
    total++;
    if (ds !== 1'b1 || bc != 256 || pb != 0) begin
      bad++;
      $display("FAIL %s_timing: got done=%0d busy=%0d pi_err=%0d want 1 256 0", tag, ds, bc, pb);
    end
    sample_obs(1);
    want = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs[i] !== want[i]) begin
        bad++;
        $display("FAIL %s_%s: got %0d want %0d", tag, nm[i], obs[i], want[i]);
      end
    end
    @(negedge clk);
    total++;
    if (done_a[1] !== 1'b0 || busy_a[1] !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse: got done=%b busy=%b want 0 0", tag, done_a[1], busy_a[1]);
    end
  endtask

  task automatic test_settle();
    int bc, pb; bit ds;
    set_tables(3);
    for (int k = 0; k < 2; k++) begin
      int sel, len;
      sel = (k == 0) ? 0 : 2;
      len = (k == 0) ? 128 : 512;
      run_sweep(sel, 1'b1, -1, -1, bc, pb, ds);
      total++;
      if (ds !== 1'b1 || bc != len || pb != 0) begin
        bad++;
        $display("FAIL settle[%0d]_timing: got done=%0d busy=%0d pi_err=%0d want 1 %0d 0", sel, ds, bc, pb, len);
      end
      sample_obs(sel);
      want = '{1, 1, 1, 1, 'h55};
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs[i] !== want[i]) begin
          bad++;
          $display("FAIL settle[%0d]_%s: got %0d want %0d", sel, nm[i], obs[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int bc, pb, len; bit ds;
    for (int it = 0; it < 3; it++) begin
      set_tables(4);
      model();
      len = (it == 0) ? 128 : (it == 1) ? 256 : 512;
      run_sweep(it, 1'b1, -1, -1, bc, pb, ds);
      total++;
      if (ds !== 1'b1 || bc != len || pb != 0) begin
        bad++;
        $display("FAIL random[%0d]_timing: got done=%0d busy=%0d pi_err=%0d want 1 %0d 0", it, ds, bc, pb, len);
      end
      sample_obs(it);
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs[i] !== want[i]) begin
          bad++;
          $display("FAIL random[%0d]_%s: got %0d want %0d", it, nm[i], obs[i], want[i]);
        end
      end
    end
  endtask

  // Start pulsed mid-sweep, then held high through DONE: back-to-back sweeps.
  task automatic test_back_to_back();
    int bc, pb; bit ds;
    set_tables(1);
    model();
    run_sweep(1, 1'b1, 50, 200, bc, pb, ds);
    total++;
    if (ds !== 1'b1 || bc != 256 || pb != 0) begin
      bad++;
      $display("FAIL b2b_first_timing: got done=%0d busy=%0d pi_err=%0d want 1 256 0", ds, bc, pb);
    end
    sample_obs(1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs[i] !== want[i]) begin
        bad++;
        $display("FAIL b2b_first_%s: got %0d want %0d", nm[i], obs[i], want[i]);
      end
    end
    @(negedge clk);
    total++;
    if (done_a[1] !== 1'b0 || busy_a[1] !== 1'b1 || pi_a[1] !== 7'd0 || err_a[1] !== 8'd0) begin
      bad++;
      $display("FAIL b2b_restart: got done=%b busy=%b pi=%0d err=%0d want 0 1 0 0",
               done_a[1], busy_a[1], pi_a[1], err_a[1]);
    end
    start_a[1] = 1'b0;
    run_sweep(1, 1'b0, -1, -1, bc, pb, ds);
    total++;
    if (ds !== 1'b1 || bc != 256 || pb != 0) begin
      bad++;
      $display("FAIL b2b_second_timing: got done=%0d busy=%0d pi_err=%0d want 1 256 0", ds, bc, pb);
    end
    sample_obs(1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs[i] !== want[i]) begin
        bad++;
        $display("FAIL b2b_second_%s: got %0d want %0d", nm[i], obs[i], want[i]);
      end
    end
    @(negedge clk);
    total++;
    if (done_a[1] !== 1'b0 || busy_a[1] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: got done=%b busy=%b want 0 0", done_a[1], busy_a[1]);
    end
  endtask

  task automatic test_reset_mid();
    int bc, pb; bit ds, hit;
    set_tables(1);
    @(negedge clk); start_a[1] = 1'b1;
    @(negedge clk); start_a[1] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (pi_a[1] == 7'd40) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (hit !== 1'b1 || err_a[1] !== 8'd20) begin
      bad++;
      $display("FAIL rstmid_reach: got reached=%0d err=%0d want 1 20", hit, err_a[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    sample_obs(1);
    total++;
    if (busy_a[1] !== 1'b0 || done_a[1] !== 1'b0 || pi_a[1] !== 7'd0 ||
        obs[0] != 0 || obs[1] != 0 || obs[2] != 0 || obs[3] != 0 || obs[4] != 0) begin
      bad++;
      $display("FAIL rstmid_clear: got busy=%b pi=%0d err=%0d hd=%0d abs=%0d max=%0d ff=%0d want all 0",
               busy_a[1], pi_a[1], obs[0], obs[1], obs[2], obs[3], obs[4]);
    end
    @(negedge clk); rst_n = 1'b1;
    run_sweep(1, 1'b1, -1, -1, bc, pb, ds);
    total++;
    if (ds !== 1'b1 || bc != 256 || pb != 0) begin
      bad++;
      $display("FAIL rstmid_timing: got done=%0d busy=%0d pi_err=%0d want 1 256 0", ds, bc, pb);
    end
    sample_obs(1);
    want = '{64, 64, 64, 1, 1};
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs[i] !== want[i]) begin
        bad++;
        $display("FAIL rstmid_%s: got %0d want %0d", nm[i], obs[i], want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern(0, "identity", 0, 0, 0, 0, 0);
    test_pattern(1, "stuck0", 64, 64, 64, 1, 1);
    test_pattern(2, "inverted", 128, 512, 1024, 15, 0);
    test_settle();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
